uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, line baud rate.
REQ-003 SHALL have parameter GAP_BYTES, default 4, inter-byte timeout expressed in 10-bit character times.
REQ-004 SHALL have ports: sys_clk  in  1  system clock.
REQ-005 SHALL have ports: sys_rst_n  in  1  reset.
REQ-006 SHALL have ports: uart_data  in  8  received byte from the upstream UART receiver.
REQ-007 SHALL have ports: uart_done  in  1  byte-ready indication from the receiver; may be a pulse or a held level.
REQ-008 SHALL have ports: rd_addr  in  4  payload buffer read index.
REQ-009 SHALL have ports: rd_data  out  8  payload byte at rd_addr.
REQ-010 SHALL have ports: pkt_valid  out  1  verified frame available.
REQ-011 SHALL have ports: pkt_len  out  5  payload length of the held frame, 1..16.
REQ-012 SHALL have ports: pkt_ack  in  1  consumer release of the held frame.
REQ-013 SHALL have ports: err_csum, err_len, err_gap, drop  out  1 each  single-cycle error/discard pulses.
REQ-014 SHALL have ports: busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 SHALL use one clock; reset is synchronous and active-low (sys_clk, sys_rst_n).

Function
REQ-016 SHALL register uart_done once and form byte_stb = uart_done & ~uart_done_q, so a held-high uart_done yields exactly one byte event; uart_data SHALL be sampled on the byte_stb cycle.
REQ-017 SHALL parse the frame format SOF (8'h55), LEN, LEN payload bytes, CSUM, where CSUM = (LEN + sum of payload) mod 256.
REQ-018 SHALL implement FSM states IDLE, LEN, PAYLOAD, CSUM.
REQ-019 SHALL transition IDLE->LEN on a byte equal to 8'h55; non-SOF bytes in IDLE SHALL be ignored silently.
REQ-020 In LEN, SHALL accept LEN 1..16 -> PAYLOAD; LEN 0 or >16 SHALL pulse err_len and return to IDLE.
REQ-021 In PAYLOAD, SHALL write each byte to the 16x8 buffer at index 0..LEN-1 and accumulate the 8-bit checksum with wrap-around; after byte LEN-1 it SHALL go to CSUM.
REQ-022 In CSUM, on a match SHALL set pkt_valid and pkt_len on the cycle after byte_stb; on a mismatch SHALL pulse err_csum; in both cases it SHALL return to IDLE.
REQ-023 pkt_valid SHALL hold until the cycle after pkt_ack=1 is sampled; pkt_ack while pkt_valid=0 SHALL be ignored.
REQ-024 While pkt_valid=1, every byte_stb SHALL be discarded with a drop pulse, and the buffer and FSM SHALL stay unchanged.
REQ-025 On simultaneous pkt_ack and byte_stb, the byte SHALL be discarded with a drop pulse, because pkt_valid is evaluated before the ack takes effect.
REQ-026 In any non-IDLE state, the gap counter SHALL reset on each byte_stb.
REQ-027 When the gap counter reaches GAP_CYC = (CLK_FREQ/UART_BPS)*10*GAP_BYTES (17360 at the defaults), SHALL pulse err_gap and return to IDLE, discarding the partial frame.
REQ-028 rd_data SHALL be registered with 1-cycle latency from rd_addr and SHALL be valid for any address; contents beyond pkt_len are don't-care.
REQ-029 busy SHALL be high in the LEN, PAYLOAD and CSUM states.

Reset
REQ-030 On reset, SHALL set FSM=IDLE, pkt_valid=0, pkt_len=0, rd_data=0, all error and drop pulses=0, checksum=0, gap counter=0, and uart_done_q=1 (prevents a false strobe if uart_done is high at reset exit).
REQ-031 Reset SHALL NOT clear the buffer contents.
REQ-032 Reset asserted mid-frame SHALL abandon the frame without producing any error pulse.

Structure
REQ-033 The shared package uart_pkg SHALL hold the SOF constant, MAX_LEN=16, the FSM state encoding and the GAP_CYC computation function.
REQ-034 The gap counter SHALL be a sub-module uart_gap_timer (inputs: clear, enable; output: expire); the buffer SHALL be inferred in place.

Verification
REQ-035 Frame 55 03 11 22 33 69 -> pkt_valid=1, pkt_len=3, rd_addr 0/1/2 gives rd_data 11/22/33 one cycle later; pkt_ack -> pkt_valid=0 on the next cycle.
REQ-036 Frame 55 02 AA BB 00 -> err_csum pulse, pkt_valid stays 0, FSM in IDLE; a following valid frame is accepted.
REQ-037 Byte 55 then 00 -> err_len; byte 55 then 11 -> err_len; stray bytes 00 FF before SOF produce no pulse.
REQ-038 Byte 55 03 11 followed by silence > 17360 cycles -> single err_gap pulse and busy=0.
REQ-039 Two back-to-back valid frames without ack -> the first is held, every byte of the second pulses drop, and after ack the next frame is accepted.
REQ-040 uart_done held high for 1000 cycles per byte, plus uart_done high at reset release -> exactly one byte event per rising edge and none at reset exit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser.
//   SOF      : start-of-frame marker byte
//   MAX_LEN  : largest payload length a frame may declare
//   state_t  : parser FSM encoding
//   gap_cycles() : inter-byte timeout in clock cycles
package uart_pkg;

  localparam logic [7:0] SOF     = 8'h55;
  localparam int         MAX_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_t;

  // One character is 10 bits on the line (start + 8 data + stop).
  function automatic int gap_cycles(input int clk_freq, input int bps,
                                    input int gap_bytes);
    return (clk_freq / bps) * 10 * gap_bytes;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte silence timer.
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : restart the count (a byte arrived)
//   enable     : count only while a frame is in progress; held at zero otherwise
//   expire     : high while the count has reached GAP_CYC
module uart_gap_timer #(
  parameter int GAP_CYC = 17360
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int               CNT_W = $clog2(GAP_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(GAP_CYC);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LIMIT);

endmodule

// File: rtl/uart_frame_parser.sv
// Parses frames of the form SOF, LEN, LEN payload bytes, CSUM from a byte
// stream and holds one verified payload for a consumer.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   uart_data/uart_done: byte and byte-ready (pulse or level) from the receiver
//   rd_addr/rd_data    : payload buffer read port, one-cycle latency
//   pkt_valid/pkt_len  : held frame present and its payload length
//   pkt_ack            : consumer releases the held frame
//   err_csum/err_len/err_gap/drop : single-cycle error and discard pulses
//   busy               : a frame is being parsed
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int GAP_BYTES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] uart_data,
  input  logic       uart_done,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       pkt_valid,
  output logic [4:0] pkt_len,
  input  logic       pkt_ack,
  output logic       err_csum,
  output logic       err_len,
  output logic       err_gap,
  output logic       drop,
  output logic       busy
);

  localparam int GAP_CYC = gap_cycles(CLK_FREQ, UART_BPS, GAP_BYTES);

  state_t     state, state_nxt;
  logic       uart_done_q;
  logic       byte_stb, take, len_ok, gap_expire;
  logic       len_bad, csum_bad, csum_good, gap_hit, buf_we;
  logic [4:0] len_q;
  logic [3:0] idx;
  logic [7:0] csum;
  logic [7:0] mem [MAX_LEN];

  // Edge detect so a held-high uart_done counts as one byte.
  assign byte_stb = uart_done & ~uart_done_q;
  // A held frame blocks all new input; those bytes are reported via drop.
  assign take     = byte_stb & ~pkt_valid;
  assign len_ok   = (uart_data != 8'd0) && (uart_data <= 8'(MAX_LEN));
  assign busy     = (state != ST_IDLE);

  uart_gap_timer #(
    .GAP_CYC (GAP_CYC)
  ) u_gap (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clear  (byte_stb),
    .enable (busy),
    .expire (gap_expire)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    len_bad   = 1'b0;
    csum_bad  = 1'b0;
    csum_good = 1'b0;
    gap_hit   = 1'b0;
    buf_we    = 1'b0;
    // A timeout wins over a byte landing on the same cycle.
    if (gap_expire) begin
      gap_hit   = 1'b1;
      state_nxt = ST_IDLE;
    end else if (take) begin
      unique case (state)
        ST_IDLE: begin
          if (uart_data == SOF) state_nxt = ST_LEN;
        end
        ST_LEN: begin
          if (len_ok) begin
            state_nxt = ST_PAYLOAD;
          end else begin
            len_bad   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          buf_we = 1'b1;
          if ((5'(idx) + 5'd1) == len_q) state_nxt = ST_CSUM;
        end
        ST_CSUM: begin
          state_nxt = ST_IDLE;
          if (uart_data == csum) csum_good = 1'b1;
          else                   csum_bad  = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      uart_done_q <= 1'b1;
      pkt_valid   <= 1'b0;
      pkt_len     <= '0;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_gap     <= 1'b0;
      drop        <= 1'b0;
      csum        <= '0;
      len_q       <= '0;
      idx         <= '0;
      rd_data     <= '0;
    end else begin
      uart_done_q <= uart_done;
      err_csum    <= csum_bad;
      err_len     <= len_bad;
      err_gap     <= gap_hit;
      drop        <= byte_stb & pkt_valid;
      rd_data     <= mem[rd_addr];
      if (csum_good) begin
        pkt_valid <= 1'b1;
        pkt_len   <= len_q;
      end else if (pkt_valid && pkt_ack) begin
        pkt_valid <= 1'b0;
      end
      // The checksum starts from LEN itself.
      if (take && state == ST_LEN) begin
        len_q <= uart_data[4:0];
        csum  <= uart_data;
        idx   <= '0;
      end
      if (buf_we) begin
        csum <= csum + uart_data;
        idx  <= idx + 4'd1;
      end
    end
  end

  // Buffer is not reset: a reset only abandons framing state.
  always_ff @(posedge sys_clk) begin
    if (buf_we) mem[idx] <= uart_data;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser.
module tb_uart_frame_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] uart_data;
  logic       uart_done;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       pkt_valid;
  logic [4:0] pkt_len;
  logic       pkt_ack;
  logic       err_csum, err_len, err_gap, drop, busy;

  int n_cmp = 0;
  int n_err = 0;
  int c_csum = 0, c_len = 0, c_gap = 0, c_drop = 0;
  int s_csum, s_len, s_gap, s_drop;

  always #5 clk = ~clk;

  uart_frame_parser dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .uart_data (uart_data),
    .uart_done (uart_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pkt_valid (pkt_valid),
    .pkt_len   (pkt_len),
    .pkt_ack   (pkt_ack),
    .err_csum  (err_csum),
    .err_len   (err_len),
    .err_gap   (err_gap),
    .drop      (drop),
    .busy      (busy)
  );

  // Pulse counters; each single-cycle pulse is seen at exactly one edge.
  always @(posedge clk) begin
    if (err_csum) c_csum++;
    if (err_len)  c_len++;
    if (err_gap)  c_gap++;
    if (drop)     c_drop++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_csum = c_csum; s_len = c_len; s_gap = c_gap; s_drop = c_drop;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_data = b;
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
    tick();
  endtask

  task automatic send_held(input logic [7:0] b);
    uart_data = b;
    uart_done = 1'b1;
    repeat (1000) tick();
    uart_done = 1'b0;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    chk("ack_clears_valid", 32'(pkt_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    uart_data = 8'h55;
    uart_done = 1'b1;
    rd_addr   = 4'd0;
    pkt_ack   = 1'b0;
    repeat (5) tick();
    chk("rst_valid",  32'(pkt_valid), 32'd0);
    chk("rst_len",    32'(pkt_len),   32'd0);
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_rddata", 32'(rd_data),   32'd0);
    // uart_done high across reset exit must not create a byte
    snap();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rst_exit_no_strobe", 32'(busy), 32'd0);
    uart_done = 1'b0;
    tick();
    // ack with nothing held is ignored
    pkt_ack = 1'b1; tick(); pkt_ack = 1'b0; tick();
    chk("rst_exit_no_pulses", 32'(c_len + c_csum + c_gap + c_drop - s_len - s_csum - s_gap - s_drop), 32'd0);

    // Basic frame
    send_byte(8'h55); send_byte(8'h03);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    chk("f1_valid", 32'(pkt_valid), 32'd1);
    chk("f1_len",   32'(pkt_len),   32'd3);
    chk("f1_busy",  32'(busy),      32'd0);
    rd_chk("f1_rd0", 4'd0, 8'h11);
    rd_chk("f1_rd1", 4'd1, 8'h22);
    rd_chk("f1_rd2", 4'd2, 8'h33);
    ack();

    // Bad checksum, then a good frame
    snap();
    send_byte(8'h55); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h00);
    chk("csum_err_pulse", 32'(c_csum - s_csum), 32'd1);
    chk("csum_err_valid", 32'(pkt_valid), 32'd0);
    chk("csum_err_idle",  32'(busy), 32'd0);
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    chk("f2_valid", 32'(pkt_valid), 32'd1);
    chk("f2_len",   32'(pkt_len),   32'd1);
    rd_chk("f2_rd0", 4'd0, 8'h7F);
    ack();

    // Stray bytes, bad lengths
    snap();
    send_byte(8'h00); send_byte(8'hFF);
    chk("stray_no_pulse", 32'(c_len + c_csum + c_gap + c_drop - s_len - s_csum - s_gap - s_drop), 32'd0);
    chk("stray_idle", 32'(busy), 32'd0);
    send_byte(8'h55); send_byte(8'h00);
    chk("len0_err", 32'(c_len - s_len), 32'd1);
    send_byte(8'h55); send_byte(8'h11);
    chk("len17_err", 32'(c_len - s_len), 32'd2);
    chk("len_err_idle", 32'(busy), 32'd0);

    // Maximum length frame: csum = 16 + (1+..+16) = 152
    send_byte(8'h55); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h98);
    chk("f16_valid", 32'(pkt_valid), 32'd1);
    chk("f16_len",   32'(pkt_len),   32'd16);
    rd_chk("f16_rd15", 4'd15, 8'h10);
    rd_chk("f16_rd0",  4'd0,  8'h01);
    ack();

    // Inter-byte timeout
    snap();
    send_byte(8'h55); send_byte(8'h03); send_byte(8'h11);
    repeat (17300) tick();
    chk("gap_not_yet", 32'(c_gap - s_gap), 32'd0);
    chk("gap_busy_before", 32'(busy), 32'd1);
    repeat (100) tick();
    chk("gap_pulse", 32'(c_gap - s_gap), 32'd1);
    chk("gap_idle", 32'(busy), 32'd0);

    // Second frame while the first is held is dropped
    snap();
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
    chk("fa_valid", 32'(pkt_valid), 32'd1);
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h09); send_byte(8'h0A);
    chk("fb_drops", 32'(c_drop - s_drop), 32'd4);
    chk("fb_len_held", 32'(pkt_len), 32'd2);
    chk("fb_idle", 32'(busy), 32'd0);
    rd_chk("fb_buf0", 4'd0, 8'h01);
    rd_chk("fb_buf1", 4'd1, 8'h02);
    ack();
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h09); send_byte(8'h0A);
    chk("fc_valid", 32'(pkt_valid), 32'd1);
    rd_chk("fc_rd0", 4'd0, 8'h09);

    // Ack and byte on the same cycle: byte is dropped
    snap();
    uart_data = 8'h55;
    uart_done = 1'b1;
    pkt_ack   = 1'b1;
    tick();
    uart_done = 1'b0;
    pkt_ack   = 1'b0;
    tick();
    chk("ack_byte_drop", 32'(c_drop - s_drop), 32'd1);
    chk("ack_byte_valid", 32'(pkt_valid), 32'd0);
    chk("ack_byte_idle", 32'(busy), 32'd0);

    // uart_done held high per byte
    snap();
    send_held(8'h55); send_held(8'h01); send_held(8'h42); send_held(8'h43);
    chk("held_valid", 32'(pkt_valid), 32'd1);
    chk("held_len",   32'(pkt_len),   32'd1);
    chk("held_no_drop", 32'(c_drop - s_drop), 32'd0);
    rd_chk("held_rd0", 4'd0, 8'h42);
    ack();

    // Reset mid-frame abandons it silently
    snap();
    send_byte(8'h55); send_byte(8'h03); send_byte(8'h44);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_idle", 32'(busy), 32'd0);
    chk("midrst_no_pulses", 32'(c_len + c_csum + c_gap + c_drop - s_len - s_csum - s_gap - s_drop), 32'd0);
    chk("midrst_valid", 32'(pkt_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
